fifo_multiport: RTL and testbench

- Parametrised successor to the single-lane circular FIFO.
- Accepts up to ENQ_LANES entries and retires up to DEQ_LANES entries per cycle, in order.
- Adds a synchronous flush and occupancy/free-slot outputs.
- Serves as the superscalar buffer between fetch/decode and dispatch in the OOO core, and as a generic multi-wide queue elsewhere.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_multiport_if.sv | 29 ++
 rtl/fifo_multiport_lane_prefix_count.sv | 18 +
 rtl/fifo_multiport.sv | 80 ++++++++
 tb/tb_fifo_multiport.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and lane-prefix arithmetic for the multi-lane FIFO.
package fifo_pkg;

    localparam int unsigned MAX_LANES = 32;

    function automatic int unsigned ptr_width(input int unsigned n_entries);
        return $clog2(n_entries);
    endfunction

    // One extra bit distinguishes full from empty when pointers match.
    function automatic int unsigned ctr_width(input int unsigned n_entries);
        return ptr_width(n_entries) + 1;
    endfunction

    function automatic int unsigned leading_ones_count(input logic [MAX_LANES-1:0] vec,
                                                       input int unsigned          lanes);
        int unsigned cnt;
        logic        run;
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < int'(lanes) && run) begin
                if (vec[i]) cnt = cnt + 1;
                else        run = 1'b0;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fifo_multiport_if.sv
// Producer/consumer bundle for fifo_multiport; master drives requests, slave is the FIFO.
interface fifo_multiport_if #(
    parameter int unsigned ENTRY_WIDTH = 32,
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned ENQ_LANES   = 2,
    parameter int unsigned DEQ_LANES   = 2
);
    localparam int unsigned CTR_WIDTH = $clog2(N_ENTRIES) + 1;

    logic                                  flush;
    logic [ENQ_LANES-1:0]                  enq_valid;
    logic [ENQ_LANES-1:0][ENTRY_WIDTH-1:0] enq_data;
    logic [ENQ_LANES-1:0]                  enq_ready;
    logic [DEQ_LANES-1:0]                  deq_ready;
    logic [DEQ_LANES-1:0]                  deq_valid;
    logic [DEQ_LANES-1:0][ENTRY_WIDTH-1:0] deq_data;
    logic [CTR_WIDTH-1:0]                  occupancy;
    logic [CTR_WIDTH-1:0]                  free_slots;

    modport master (
        output flush, enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, occupancy, free_slots
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, occupancy, free_slots
    );
endinterface

// File: rtl/fifo_multiport_lane_prefix_count.sv
// Combinational count of the leading run of ones starting at lane 0.
module lane_prefix_count
    import fifo_pkg::*;
#(
    parameter  int unsigned LANES     = 2,
    localparam int unsigned CNT_WIDTH = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0]     i_vec,
    output logic [CNT_WIDTH-1:0] o_count
);
    logic [MAX_LANES-1:0] w_vec;

    always_comb begin
        w_vec            = '0;
        w_vec[LANES-1:0] = i_vec;
        o_count          = CNT_WIDTH'(leading_ones_count(w_vec, LANES));
    end
endmodule

// File: rtl/fifo_multiport.sv
// In-order multi-lane circular FIFO with synchronous flush and occupancy reporting.
module fifo_multiport
    import fifo_pkg::*;
#(
    parameter int unsigned ENTRY_WIDTH = 32,
    parameter int unsigned N_ENTRIES   = 8,
    parameter int unsigned ENQ_LANES   = 2,
    parameter int unsigned DEQ_LANES   = 2
) (
    input logic             clk,
    input logic             rst_aL,
    fifo_multiport_if.slave bus
);
    localparam int unsigned PTR_WIDTH = ptr_width(N_ENTRIES);
    localparam int unsigned CTR_WIDTH = ctr_width(N_ENTRIES);
    localparam int unsigned ENQ_CW    = $clog2(ENQ_LANES + 1);
    localparam int unsigned DEQ_CW    = $clog2(DEQ_LANES + 1);

    logic [CTR_WIDTH-1:0]   r_enq_ctr, r_deq_ctr;
    logic [ENTRY_WIDTH-1:0] r_mem [N_ENTRIES];

    logic [CTR_WIDTH-1:0] w_occupancy, w_free_slots;
    logic [PTR_WIDTH-1:0] w_enq_ptr, w_deq_ptr;
    logic [ENQ_LANES-1:0] w_enq_ready, w_enq_fire;
    logic [DEQ_LANES-1:0] w_deq_valid, w_deq_fire;
    logic [ENQ_CW-1:0]    w_n_enq;
    logic [DEQ_CW-1:0]    w_n_deq;

    // Readiness and visibility come from registered counters only: no bypass, no same-cycle credit.
    always_comb begin
        w_enq_ptr    = r_enq_ctr[PTR_WIDTH-1:0];
        w_deq_ptr    = r_deq_ctr[PTR_WIDTH-1:0];
        w_occupancy  = r_enq_ctr - r_deq_ctr;
        w_free_slots = CTR_WIDTH'(N_ENTRIES) - w_occupancy;
        for (int i = 0; i < ENQ_LANES; i++) begin
            w_enq_ready[i] = w_free_slots > CTR_WIDTH'(i);
            w_enq_fire[i]  = bus.enq_valid[i] & w_enq_ready[i];
        end
        for (int i = 0; i < DEQ_LANES; i++) begin
            w_deq_valid[i] = w_occupancy > CTR_WIDTH'(i);
            w_deq_fire[i]  = w_deq_valid[i] & bus.deq_ready[i];
        end
    end

    always_comb begin
        bus.enq_ready  = w_enq_ready;
        bus.deq_valid  = w_deq_valid;
        bus.occupancy  = w_occupancy;
        bus.free_slots = w_free_slots;
        for (int i = 0; i < DEQ_LANES; i++) begin
            bus.deq_data[i] = r_mem[w_deq_ptr + PTR_WIDTH'(i)];
        end
    end

    lane_prefix_count #(.LANES(ENQ_LANES)) u_enq_count (
        .i_vec   (w_enq_fire),
        .o_count (w_n_enq)
    );

    lane_prefix_count #(.LANES(DEQ_LANES)) u_deq_count (
        .i_vec   (w_deq_fire),
        .o_count (w_n_deq)
    );

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_enq_ctr <= '0;
            r_deq_ctr <= '0;
            for (int k = 0; k < N_ENTRIES; k++) r_mem[k] <= '0;
        end else if (bus.flush) begin
            r_deq_ctr <= r_enq_ctr;
        end else begin
            r_enq_ctr <= r_enq_ctr + CTR_WIDTH'(w_n_enq);
            r_deq_ctr <= r_deq_ctr + CTR_WIDTH'(w_n_deq);
            for (int k = 0; k < ENQ_LANES; k++) begin
                if (ENQ_CW'(k) < w_n_enq) r_mem[w_enq_ptr + PTR_WIDTH'(k)] <= bus.enq_data[k];
            end
        end
    end
endmodule

// File: tb/tb_fifo_multiport.sv
// Directed-vector bench for fifo_multiport at 8 entries, 2 enqueue and 2 dequeue lanes.
module tb_fifo_multiport;
    localparam int unsigned EW = 32;
    localparam int unsigned NE = 8;
    localparam int unsigned EL = 2;
    localparam int unsigned DL = 2;

    logic clk;
    logic rst_aL;
    int   n_vec;
    int   n_err;

    fifo_multiport_if #(.ENTRY_WIDTH(EW), .N_ENTRIES(NE), .ENQ_LANES(EL), .DEQ_LANES(DL)) bus ();

    fifo_multiport #(.ENTRY_WIDTH(EW), .N_ENTRIES(NE), .ENQ_LANES(EL), .DEQ_LANES(DL)) dut (
        .clk    (clk),
        .rst_aL (rst_aL),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush     = 1'b0;
        bus.enq_valid = '0;
        bus.enq_data  = '0;
        bus.deq_ready = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_aL = 1'b0;
        repeat (3) cycle();
        rst_aL = 1'b1;
        cycle();
    endtask

    task automatic enq2(input logic [EW-1:0] d0, input logic [EW-1:0] d1);
        bus.enq_valid = 2'b11;
        bus.enq_data  = {d1, d0};
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_aL = 1'b0;
        repeat (3) cycle();
        n_vec++;
        if (bus.deq_data !== '0) begin
            n_err++; $display("FAIL reset_hold_data: got %h expected 0", bus.deq_data);
        end
        rst_aL = 1'b1;
        cycle();
        n_vec++;
        if (bus.enq_ready !== 2'b11) begin
            n_err++; $display("FAIL reset_enq_ready: got %b expected 11", bus.enq_ready);
        end
        n_vec++;
        if (bus.deq_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_deq_valid: got %b expected 00", bus.deq_valid);
        end
        n_vec++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL reset_occupancy: got %0d expected 0", bus.occupancy);
        end
        n_vec++;
        if (bus.free_slots !== 4'd8) begin
            n_err++; $display("FAIL reset_free_slots: got %0d expected 8", bus.free_slots);
        end
    endtask

    task automatic test_dual();
        do_reset();
        enq2(32'hAAAA_0001, 32'hBBBB_0002);
        n_vec++;
        if (bus.deq_valid !== 2'b11 || bus.occupancy !== 4'd2) begin
            n_err++; $display("FAIL dual_latency: got valid=%b occ=%0d expected valid=11 occ=2",
                              bus.deq_valid, bus.occupancy);
        end
        enq2(32'hCCCC_0003, 32'hDDDD_0004);
        n_vec++;
        if (bus.occupancy !== 4'd4) begin
            n_err++; $display("FAIL dual_occ4: got %0d expected 4", bus.occupancy);
        end
        n_vec++;
        if (bus.deq_data[0] !== 32'hAAAA_0001 || bus.deq_data[1] !== 32'hBBBB_0002) begin
            n_err++; $display("FAIL dual_head_ab: got %h/%h expected aaaa0001/bbbb0002",
                              bus.deq_data[0], bus.deq_data[1]);
        end
        bus.deq_ready = 2'b11;
        cycle();
        idle();
        n_vec++;
        if (bus.deq_data[0] !== 32'hCCCC_0003 || bus.deq_data[1] !== 32'hDDDD_0004) begin
            n_err++; $display("FAIL dual_head_cd: got %h/%h expected cccc0003/dddd0004",
                              bus.deq_data[0], bus.deq_data[1]);
        end
        n_vec++;
        if (bus.occupancy !== 4'd2) begin
            n_err++; $display("FAIL dual_occ2: got %0d expected 2", bus.occupancy);
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 4; i++) enq2(32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i));
        n_vec++;
        if (bus.occupancy !== 4'd8 || bus.free_slots !== 4'd0) begin
            n_err++; $display("FAIL full_occ: got occ=%0d free=%0d expected occ=8 free=0",
                              bus.occupancy, bus.free_slots);
        end
        n_vec++;
        if (bus.enq_ready !== 2'b00) begin
            n_err++; $display("FAIL full_enq_ready: got %b expected 00", bus.enq_ready);
        end
        bus.enq_valid = 2'b11;
        bus.enq_data  = {32'hDEAD_0001, 32'hDEAD_0000};
        bus.deq_ready = 2'b01;
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd7) begin
            n_err++; $display("FAIL full_no_credit_occ: got %0d expected 7", bus.occupancy);
        end
        n_vec++;
        if (bus.enq_ready !== 2'b01) begin
            n_err++; $display("FAIL full_enq_ready_01: got %b expected 01", bus.enq_ready);
        end
        n_vec++;
        if (bus.deq_data[0] !== 32'h101) begin
            n_err++; $display("FAIL full_head: got %h expected 00000101", bus.deq_data[0]);
        end
    endtask

    task automatic test_wrap();
        logic [EW-1:0] exp_q [4];
        exp_q[0] = 32'h5800_0000;
        exp_q[1] = 32'h5900_0001;
        exp_q[2] = 32'h5A00_0002;
        exp_q[3] = 32'h5700_0003;
        do_reset();
        for (int i = 0; i < 3; i++) enq2(32'h200 + 32'(i), 32'h300 + 32'(i));
        bus.deq_ready = 2'b11;
        repeat (3) cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL wrap_drained: got %0d expected 0", bus.occupancy);
        end
        enq2(exp_q[0], exp_q[1]);
        enq2(exp_q[2], exp_q[3]);
        n_vec++;
        if (dut.r_enq_ctr !== 4'b1010) begin
            n_err++; $display("FAIL wrap_enq_ctr: got %b expected 1010", dut.r_enq_ctr);
        end
        for (int p = 0; p < 2; p++) begin
            n_vec++;
            if (bus.deq_data[0] !== exp_q[2*p] || bus.deq_data[1] !== exp_q[2*p+1]) begin
                n_err++; $display("FAIL wrap_order_%0d: got %h/%h expected %h/%h", p,
                                  bus.deq_data[0], bus.deq_data[1], exp_q[2*p], exp_q[2*p+1]);
            end
            bus.deq_ready = 2'b11;
            cycle();
            idle();
        end
        n_vec++;
        if (bus.occupancy !== 4'd0 || bus.deq_valid !== 2'b00) begin
            n_err++; $display("FAIL wrap_empty: got occ=%0d valid=%b expected occ=0 valid=00",
                              bus.occupancy, bus.deq_valid);
        end
    endtask

    task automatic test_partial();
        do_reset();
        bus.enq_valid = 2'b10;
        bus.enq_data  = {32'hBAD0_0001, 32'hBAD0_0000};
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd0) begin
            n_err++; $display("FAIL gap_no_write: got %0d expected 0", bus.occupancy);
        end
        for (int i = 0; i < 3; i++) enq2(32'h400 + 32'(i), 32'h500 + 32'(i));
        bus.enq_valid = 2'b01;
        bus.enq_data  = {32'h0, 32'h600};
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd7 || bus.enq_ready !== 2'b01) begin
            n_err++; $display("FAIL part_occ7: got occ=%0d rdy=%b expected occ=7 rdy=01",
                              bus.occupancy, bus.enq_ready);
        end
        enq2(32'h700, 32'h701);
        n_vec++;
        if (bus.occupancy !== 4'd8) begin
            n_err++; $display("FAIL part_lane0_only: got %0d expected 8", bus.occupancy);
        end
        bus.deq_ready = 2'b10;
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd8 || bus.deq_data[0] !== 32'h400) begin
            n_err++; $display("FAIL deq_gap: got occ=%0d head=%h expected occ=8 head=00000400",
                              bus.occupancy, bus.deq_data[0]);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        enq2(32'h800, 32'h801);
        enq2(32'h802, 32'h803);
        bus.enq_valid = 2'b01;
        bus.enq_data  = {32'h0, 32'h804};
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd5) begin
            n_err++; $display("FAIL flush_pre_occ: got %0d expected 5", bus.occupancy);
        end
        bus.flush     = 1'b1;
        bus.enq_valid = 2'b11;
        bus.enq_data  = {32'hF00D_0001, 32'hF00D_0000};
        bus.deq_ready = 2'b11;
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd0 || bus.deq_valid !== 2'b00 || bus.free_slots !== 4'd8) begin
            n_err++; $display("FAIL flush_empty: got occ=%0d valid=%b free=%0d expected 0/00/8",
                              bus.occupancy, bus.deq_valid, bus.free_slots);
        end
        enq2(32'h900, 32'h901);
        bus.enq_valid = 2'b01;
        bus.enq_data  = {32'h0, 32'h902};
        cycle();
        idle();
        n_vec++;
        if (bus.occupancy !== 4'd3 || bus.deq_data[0] !== 32'h900) begin
            n_err++; $display("FAIL post_flush_enq: got occ=%0d head=%h expected occ=3 head=00000900",
                              bus.occupancy, bus.deq_data[0]);
        end
        #2;
        rst_aL = 1'b0;
        #1;
        n_vec++;
        if (bus.occupancy !== 4'd0 || bus.deq_data !== '0) begin
            n_err++; $display("FAIL async_reset: got occ=%0d data=%h expected occ=0 data=0",
                              bus.occupancy, bus.deq_data);
        end
        n_vec++;
        if (bus.enq_ready !== 2'b11 || bus.deq_valid !== 2'b00) begin
            n_err++; $display("FAIL async_reset_hs: got rdy=%b valid=%b expected 11/00",
                              bus.enq_ready, bus.deq_valid);
        end
        cycle();
        rst_aL = 1'b1;
        cycle();
        n_vec++;
        if (bus.occupancy !== 4'd0 || bus.free_slots !== 4'd8) begin
            n_err++; $display("FAIL post_reset: got occ=%0d free=%0d expected 0/8",
                              bus.occupancy, bus.free_slots);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_aL = 1'b1;
        idle();
        test_reset();
        test_dual();
        test_fill();
        test_wrap();
        test_partial();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
